// File: rtl/btisa_encoder_pkg.sv
// Shared BTISA encoder types: trit encoding, mnemonic codes, field limits
// and the mnemonic -> opcode trit lookup (also used by assembler-side benches).
// No optional features live here; BTISA_ENC_IMM_SAT_EN is consumed by the top.
package btisa_encoder_pkg;

  // 2'b10 is never produced.
  typedef enum logic [1:0] {
    T_ZERO    = 2'b00,
    T_POS_ONE = 2'b01,
    T_NEG_ONE = 2'b11
  } trit_t;

  typedef trit_t [2:0] btisa_op_t;     // [2] = instruction trit 8
  typedef trit_t [8:0] btisa_instr_t;  // [8:6] op, [5:4] rd, [3:2] rs1, [1:0] imm

  // Codes 27..31 are not mnemonics and are rejected by the encoder.
  typedef enum logic [4:0] {
    ADD, SUB, NEG, MUL, SHL, SHR,
    BEQ, ADDI, BNE, BLT,
    MIN, MAX, XOR, INV, PTI, NTI,
    JAL, JALR, JR,
    LD, ST, LDT, STT, LUI,
    NOP, HALT, ECALL
  } btisa_mnem_e;

  localparam int BTISA_MNEM_LAST = 26;
  localparam int BTISA_FIELD_MIN = -4;
  localparam int BTISA_FIELD_MAX = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_DONE
  } btisa_enc_state_e;

  function automatic btisa_op_t btisa_op3(trit_t t8, trit_t t7, trit_t t6);
    btisa_op_t op;
    op[2] = t8;
    op[1] = t7;
    op[0] = t6;
    return op;
  endfunction

  // BEQ and ADDI share 0-0; -+- has no mnemonic.
  function automatic btisa_op_t btisa_opcode_trits(btisa_mnem_e m);
    case (m)
      ADD:     return btisa_op3(T_ZERO,    T_ZERO,    T_ZERO);
      SUB:     return btisa_op3(T_ZERO,    T_ZERO,    T_POS_ONE);
      NEG:     return btisa_op3(T_ZERO,    T_ZERO,    T_NEG_ONE);
      MUL:     return btisa_op3(T_ZERO,    T_POS_ONE, T_ZERO);
      SHL:     return btisa_op3(T_ZERO,    T_POS_ONE, T_POS_ONE);
      SHR:     return btisa_op3(T_ZERO,    T_POS_ONE, T_NEG_ONE);
      BEQ:     return btisa_op3(T_ZERO,    T_NEG_ONE, T_ZERO);
      ADDI:    return btisa_op3(T_ZERO,    T_NEG_ONE, T_ZERO);
      BNE:     return btisa_op3(T_ZERO,    T_NEG_ONE, T_POS_ONE);
      BLT:     return btisa_op3(T_ZERO,    T_NEG_ONE, T_NEG_ONE);
      MIN:     return btisa_op3(T_POS_ONE, T_ZERO,    T_ZERO);
      MAX:     return btisa_op3(T_POS_ONE, T_ZERO,    T_POS_ONE);
      XOR:     return btisa_op3(T_POS_ONE, T_ZERO,    T_NEG_ONE);
      INV:     return btisa_op3(T_POS_ONE, T_POS_ONE, T_ZERO);
      PTI:     return btisa_op3(T_POS_ONE, T_POS_ONE, T_POS_ONE);
      NTI:     return btisa_op3(T_POS_ONE, T_POS_ONE, T_NEG_ONE);
      JAL:     return btisa_op3(T_POS_ONE, T_NEG_ONE, T_ZERO);
      JALR:    return btisa_op3(T_POS_ONE, T_NEG_ONE, T_POS_ONE);
      JR:      return btisa_op3(T_POS_ONE, T_NEG_ONE, T_NEG_ONE);
      LD:      return btisa_op3(T_NEG_ONE, T_ZERO,    T_ZERO);
      ST:      return btisa_op3(T_NEG_ONE, T_ZERO,    T_POS_ONE);
      LDT:     return btisa_op3(T_NEG_ONE, T_ZERO,    T_NEG_ONE);
      STT:     return btisa_op3(T_NEG_ONE, T_POS_ONE, T_ZERO);
      LUI:     return btisa_op3(T_NEG_ONE, T_POS_ONE, T_POS_ONE);
      NOP:     return btisa_op3(T_NEG_ONE, T_NEG_ONE, T_ZERO);
      HALT:    return btisa_op3(T_NEG_ONE, T_NEG_ONE, T_POS_ONE);
      ECALL:   return btisa_op3(T_NEG_ONE, T_NEG_ONE, T_NEG_ONE);
      default: return btisa_op3(T_ZERO,    T_ZERO,    T_ZERO);
    endcase
  endfunction

endpackage

// File: rtl/btisa_encoder_if.sv
// Request/response bus of the BTISA encoder.
// slave: encoder side; master: loader / debug port side.
// Request: in_valid/in_ready + mnemonic and fields; response: out_valid/out_ready
// + instruction word, write address and error flag; addr_clr clears the address.
interface btisa_encoder_if #(
  parameter int ADDR_W = 8,
  parameter int FLD_W  = 4
);
  import btisa_encoder_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic [4:0]               in_mnem;
  logic signed [FLD_W-1:0]  in_rd;
  logic signed [FLD_W-1:0]  in_rs1;
  logic signed [FLD_W-1:0]  in_imm;
  logic                     addr_clr;
  logic                     out_valid;
  logic                     out_ready;
  btisa_instr_t             out_instr;
  logic [ADDR_W-1:0]        out_addr;
  logic                     out_err;

  modport slave (
    input  in_valid, in_mnem, in_rd, in_rs1, in_imm, addr_clr, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err
  );

  modport master (
    output in_valid, in_mnem, in_rd, in_rs1, in_imm, addr_clr, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err
  );
endinterface

// File: rtl/btisa_encoder_bt_digit_step.sv
// One balanced-ternary digit extraction step (combinational).
// Ports: v (signed working value) -> t (least significant trit), v_next ((v - t) / 3).
// Internal math is 2 bits wider so v - t never overflows for any W-bit input.
module bt_digit_step
  import btisa_encoder_pkg::*;
#(
  parameter int W = 4
) (
  input  logic signed [W-1:0] v,
  output trit_t               t,
  output logic signed [W-1:0] v_next
);
  localparam logic signed [W+1:0] K0 = (W+2)'(0);
  localparam logic signed [W+1:0] K1 = (W+2)'(1);
  localparam logic signed [W+1:0] K3 = (W+2)'(3);

  logic signed [W+1:0] vx;
  logic signed [W+1:0] rem;
  logic signed [W+1:0] q;
  logic                unused_hi;

  always_comb begin
    vx  = {{2{v[W-1]}}, v};
    // % keeps the dividend's sign; fold negatives back into 0..2.
    rem = vx % K3;
    if (rem[W+1]) rem = rem + K3;
    if (rem == K0) begin
      t = T_ZERO;
      q = vx / K3;
    end else if (rem == K1) begin
      t = T_POS_ONE;
      q = (vx - K1) / K3;
    end else begin
      t = T_NEG_ONE;
      q = (vx + K1) / K3;
    end
    v_next = q[W-1:0];
  end

  assign unused_hi = ^q[W+1:W];
endmodule

// File: rtl/btisa_encoder.sv
// Sequential BTISA instruction encoder: mnemonic + binary fields -> 9-trit word + address.
// Ports: clk, rst (async active-high), bus (btisa_encoder_if.slave).
// Latency: 7 cycles from acceptance for legal requests, 1 for illegal. Optional macro
// BTISA_ENC_IMM_SAT_EN saturates out-of-range imm to +/-4 instead of flagging it.
module btisa_encoder
  import btisa_encoder_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int FLD_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  btisa_encoder_if.slave   bus
);

  btisa_enc_state_e        state_q, state_n;
  logic [2:0]              step_q, step_n;
  logic signed [FLD_W-1:0] v_q, v_n;
  logic signed [FLD_W-1:0] rs1_q, rs1_n;
  logic signed [FLD_W-1:0] imm_q, imm_n;
  logic [4:0]              mnem_q, mnem_n;
  btisa_instr_t            instr_q, instr_n;
  logic                    err_q, err_n;
  logic [ADDR_W-1:0]       addr_q, addr_n;

  trit_t                   dig_t;
  logic signed [FLD_W-1:0] dig_v;
  logic [3:0]              pos;
  btisa_op_t               op;
  logic signed [FLD_W-1:0] imm_eff;
  logic                    imm_ok;
  logic                    req_ok;

  function automatic logic in_range(logic signed [FLD_W-1:0] x);
    int xi;
    xi = int'(x);
    return (xi >= BTISA_FIELD_MIN) && (xi <= BTISA_FIELD_MAX);
  endfunction

  function automatic logic signed [FLD_W-1:0] sat_field(logic signed [FLD_W-1:0] x);
    int xi;
    xi = int'(x);
    if (xi > BTISA_FIELD_MAX) return FLD_W'(BTISA_FIELD_MAX);
    if (xi < BTISA_FIELD_MIN) return FLD_W'(BTISA_FIELD_MIN);
    return x;
  endfunction

  // One digit unit shared by all six steps; v_q carries the field being converted.
  bt_digit_step #(.W(FLD_W)) u_step (
    .v      (v_q),
    .t      (dig_t),
    .v_next (dig_v)
  );

  always_comb begin
`ifdef BTISA_ENC_IMM_SAT_EN
    imm_eff = sat_field(bus.in_imm);
    imm_ok  = 1'b1;
`else
    imm_eff = bus.in_imm;
    imm_ok  = in_range(bus.in_imm);
`endif
    req_ok = (int'(bus.in_mnem) <= BTISA_MNEM_LAST) &&
             in_range(bus.in_rd) && in_range(bus.in_rs1) && imm_ok;
  end

  // Step -> trit slot: steps 0,1 = rd lo/hi, 2,3 = rs1, 4,5 = imm.
  always_comb begin
    case (step_q)
      3'd0:    pos = 4'd4;
      3'd1:    pos = 4'd5;
      3'd2:    pos = 4'd2;
      3'd3:    pos = 4'd3;
      3'd4:    pos = 4'd0;
      default: pos = 4'd1;
    endcase
  end

  always_comb begin
    state_n = state_q;
    step_n  = step_q;
    v_n     = v_q;
    rs1_n   = rs1_q;
    imm_n   = imm_q;
    mnem_n  = mnem_q;
    instr_n = instr_q;
    err_n   = err_q;
    addr_n  = addr_q;
    op      = btisa_opcode_trits(btisa_mnem_e'(mnem_q));

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          mnem_n = bus.in_mnem;
          v_n    = bus.in_rd;
          rs1_n  = bus.in_rs1;
          imm_n  = imm_eff;
          step_n = 3'd0;
          // Clear so nothing of the previous word survives into this one.
          for (int i = 0; i < 9; i++) instr_n[i] = T_ZERO;
          if (req_ok) begin
            state_n = S_CONV;
            err_n   = 1'b0;
          end else begin
            state_n = S_DONE;
            err_n   = 1'b1;
          end
        end
      end
      S_CONV: begin
        instr_n[pos] = dig_t;
        if (step_q == 3'd0) begin
          instr_n[8] = op[2];
          instr_n[7] = op[1];
          instr_n[6] = op[0];
        end
        // After the high trit of a field, load the next field instead of its quotient.
        case (step_q)
          3'd1:    v_n = rs1_q;
          3'd3:    v_n = imm_q;
          default: v_n = dig_v;
        endcase
        if (step_q == 3'd5) state_n = S_DONE;
        else                step_n  = step_q + 3'd1;
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_n = S_IDLE;
          if (!err_q) addr_n = addr_q + ADDR_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (bus.addr_clr) addr_n = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= 3'd0;
      v_q     <= '0;
      rs1_q   <= '0;
      imm_q   <= '0;
      mnem_q  <= '0;
      for (int i = 0; i < 9; i++) instr_q[i] <= T_ZERO;
      err_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_n;
      step_q  <= step_n;
      v_q     <= v_n;
      rs1_q   <= rs1_n;
      imm_q   <= imm_n;
      mnem_q  <= mnem_n;
      instr_q <= instr_n;
      err_q   <= err_n;
      addr_q  <= addr_n;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_instr = instr_q;
  assign bus.out_err   = err_q;
  assign bus.out_addr  = addr_q;

endmodule

// File: tb/tb_btisa_encoder.sv
// Self-checking bench for btisa_encoder with a string-table / digit-search reference model.
module tb_btisa_encoder;
  import btisa_encoder_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  btisa_encoder_if #(.ADDR_W(8), .FLD_W(4)) bif();

  btisa_encoder #(.ADDR_W(8), .FLD_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_addr = 0;

  string OPS [27] = '{
    "000", "00+", "00-", "0+0", "0++", "0+-",
    "0-0", "0-0", "0-+", "0--",
    "+00", "+0+", "+0-", "++0", "+++", "++-",
    "+-0", "+-+", "+--",
    "-00", "-0+", "-0-", "-+0", "-++",
    "--0", "--+", "---"
  };

  function automatic trit_t ch2t(byte c);
    if (c == "+") return T_POS_ONE;
    if (c == "-") return T_NEG_ONE;
    return T_ZERO;
  endfunction

  function automatic trit_t d2t(int d);
    if (d > 0) return T_POS_ONE;
    if (d < 0) return T_NEG_ONE;
    return T_ZERO;
  endfunction

  function automatic string w2s(btisa_instr_t w);
    string s = "";
    for (int i = 8; i >= 0; i--) begin
      if (w[i] == T_POS_ONE)      s = {s, "+"};
      else if (w[i] == T_NEG_ONE) s = {s, "-"};
      else if (w[i] == T_ZERO)    s = {s, "0"};
      else                        s = {s, "?"};
    end
    return s;
  endfunction

  // Expected word: opcode from the mnemonic table, each field as the unique
  // pair (hi, lo) in {-1,0,1} with lo + 3*hi == value.
  function automatic void model(input int mn, input int rd, input int rs1, input int imm,
                                output logic err, output btisa_instr_t w);
    int f [3];
    int base [3];
    string op;
    for (int i = 0; i < 9; i++) w[i] = T_ZERO;
`ifdef BTISA_ENC_IMM_SAT_EN
    if (imm > 4)  imm = 4;
    if (imm < -4) imm = -4;
`endif
    err = (mn < 0) || (mn > 26) || (rd < -4) || (rd > 4) ||
          (rs1 < -4) || (rs1 > 4) || (imm < -4) || (imm > 4);
    if (err) return;
    op = OPS[mn];
    w[8] = ch2t(op[0]);
    w[7] = ch2t(op[1]);
    w[6] = ch2t(op[2]);
    f[0] = rd;  base[0] = 4;
    f[1] = rs1; base[1] = 2;
    f[2] = imm; base[2] = 0;
    for (int k = 0; k < 3; k++)
      for (int hi = -1; hi <= 1; hi++)
        for (int lo = -1; lo <= 1; lo++)
          if (lo + 3 * hi == f[k]) begin
            w[base[k]]     = d2t(lo);
            w[base[k] + 1] = d2t(hi);
          end
  endfunction

  task automatic issue(input int mn, input int rd, input int rs1, input int imm);
    int guard = 0;
    @(negedge clk);
    while (!bif.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    bif.in_mnem  = 5'(mn);
    bif.in_rd    = 4'(rd);
    bif.in_rs1   = 4'(rs1);
    bif.in_imm   = 4'(imm);
    bif.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bif.in_valid = 1'b0;
    // Scramble the request lines; the encoder must have latched everything.
    bif.in_mnem  = 5'($urandom);
    bif.in_rd    = 4'($urandom);
    bif.in_rs1   = 4'($urandom);
    bif.in_imm   = 4'($urandom);
  endtask

  // Cycles from the acceptance edge (inclusive) until out_valid is seen; -1 on timeout.
  task automatic wait_valid(output int lat);
    lat = 1;
    @(negedge clk);
    while (!bif.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!bif.out_valid) lat = -1;
  endtask

  task automatic handshake(input logic err, input int max_delay);
    repeat ($urandom_range(0, max_delay)) @(negedge clk);
    @(negedge clk);
    bif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bif.out_ready = 1'b0;
    if (!err) exp_addr = (exp_addr + 1) % 256;
  endtask

  task automatic test_txn(input string name, input int mn, input int rd, input int rs1,
                          input int imm, input string lit, input int max_delay);
    logic         e;
    btisa_instr_t w;
    int           lat;
    int           exp_lat;
    model(mn, rd, rs1, imm, e, w);
    exp_lat = e ? 1 : 7;
    issue(mn, rd, rs1, imm);
    wait_valid(lat);
    n_checks++;
    if (lat !== exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    n_checks++;
    if (bif.out_err !== e) begin
      n_fail++;
      $display("FAIL %s out_err: got %b expected %b", name, bif.out_err, e);
    end
    n_checks++;
    if (bif.out_instr !== w) begin
      n_fail++;
      $display("FAIL %s out_instr: got %s expected %s", name, w2s(bif.out_instr), w2s(w));
    end
    n_checks++;
    if (int'(bif.out_addr) !== exp_addr) begin
      n_fail++;
      $display("FAIL %s out_addr: got %0d expected %0d", name, bif.out_addr, exp_addr);
    end
    if (lit != "") begin
      n_checks++;
      if (w2s(bif.out_instr) != lit) begin
        n_fail++;
        $display("FAIL %s literal word: got %s expected %s", name, w2s(bif.out_instr), lit);
      end
    end
    handshake(e, max_delay);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bif.in_valid = 1'b0; bif.in_mnem = '0; bif.in_rd = '0; bif.in_rs1 = '0; bif.in_imm = '0;
    bif.addr_clr = 1'b0; bif.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bif.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b expected 1", bif.in_ready); end
    n_checks++;
    if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b expected 0", bif.out_valid); end
    n_checks++;
    if (bif.out_err !== 1'b0) begin n_fail++; $display("FAIL reset out_err: got %b expected 0", bif.out_err); end
    n_checks++;
    if (bif.out_addr !== 8'd0) begin n_fail++; $display("FAIL reset out_addr: got %0d expected 0", bif.out_addr); end
    n_checks++;
    if (w2s(bif.out_instr) != "000000000") begin
      n_fail++; $display("FAIL reset out_instr: got %s expected 000000000", w2s(bif.out_instr));
    end
    exp_addr = 0;
  endtask

  task automatic test_basic();
    test_txn("add", int'(ADD), 1, -1, 4, "0000+0-++", 0);
    test_txn("halt", int'(HALT), 0, 0, 0, "--+000000", 0);
    test_txn("addi", int'(ADDI), -4, 3, -2, "0-0--+0-+", 0);
  endtask

  task automatic test_imm_range();
`ifdef BTISA_ENC_IMM_SAT_EN
    test_txn("imm5", int'(ADD), 0, 0, 5, "0000000++", 0);
    test_txn("imm-8", int'(SUB), 2, 0, -8, "00++-00--", 0);
`else
    test_txn("imm5", int'(ADD), 0, 0, 5, "000000000", 0);
    test_txn("imm-8", int'(SUB), 2, 0, -8, "000000000", 0);
`endif
  endtask

  task automatic test_illegal();
    test_txn("mnem27", 27, 0, 0, 0, "000000000", 0);
    test_txn("mnem31", 31, 1, 1, 1, "000000000", 0);
    test_txn("rd-5", int'(ADD), -5, 0, 0, "000000000", 0);
    test_txn("rs1_7", int'(MUL), 0, 7, 0, "000000000", 0);
  endtask

  task automatic test_hold();
    logic         e;
    btisa_instr_t w;
    int           lat;
    model(int'(XOR), 2, -3, 1, e, w);
    issue(int'(XOR), 2, -3, 1);
    wait_valid(lat);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (bif.out_valid !== 1'b1 || bif.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold handshake c%0d: valid=%b ready=%b expected valid=1 ready=0",
                 c, bif.out_valid, bif.in_ready);
      end
      n_checks++;
      if (bif.out_instr !== w || int'(bif.out_addr) !== exp_addr) begin
        n_fail++;
        $display("FAIL hold stable c%0d: got %s/%0d expected %s/%0d",
                 c, w2s(bif.out_instr), bif.out_addr, w2s(w), exp_addr);
      end
    end
    @(negedge clk);
    bif.addr_clr = 1'b1;
    @(posedge clk);
    #1;
    bif.addr_clr = 1'b0;
    exp_addr = 0;
    n_checks++;
    if (bif.out_addr !== 8'd0 || bif.out_valid !== 1'b1 || bif.out_instr !== w) begin
      n_fail++;
      $display("FAIL hold addr_clr: addr=%0d valid=%b word=%s expected 0/1/%s",
               bif.out_addr, bif.out_valid, w2s(bif.out_instr), w2s(w));
    end
    handshake(e, 0);
    @(negedge clk);
    n_checks++;
    if (int'(bif.out_addr) !== exp_addr) begin
      n_fail++;
      $display("FAIL hold post-handshake addr: got %0d expected %0d", bif.out_addr, exp_addr);
    end
    // addr_clr together with the handshake: the clear wins over the increment.
    issue(int'(LD), 1, 1, 1);
    wait_valid(lat);
    bif.out_ready = 1'b1;
    bif.addr_clr  = 1'b1;
    @(posedge clk);
    #1;
    bif.out_ready = 1'b0;
    bif.addr_clr  = 1'b0;
    exp_addr = 0;
    n_checks++;
    if (bif.out_addr !== 8'd0 || bif.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_wins: addr=%0d in_ready=%b expected 0/1", bif.out_addr, bif.in_ready);
    end
  endtask

  task automatic test_reset_midconv();
    test_txn("pre_rst", int'(SHL), 1, 2, 3, "", 0);
    issue(int'(SUB), 3, 3, 3);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bif.out_valid !== 1'b0 || bif.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midconv rst handshake: valid=%b ready=%b expected 0/1", bif.out_valid, bif.in_ready);
    end
    n_checks++;
    if (bif.out_addr !== 8'd0 || bif.out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL midconv rst addr/err: addr=%0d err=%b expected 0/0", bif.out_addr, bif.out_err);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_addr = 0;
    test_txn("nop_after_rst", int'(NOP), 0, 0, 0, "--0000000", 0);
  endtask

  task automatic test_random();
    int mn, rd, rs1, imm;
    for (int n = 0; n < 40; n++) begin
      mn  = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 26) : $urandom_range(0, 31);
      rd  = ($urandom_range(0, 4) != 0) ? $urandom_range(0, 8) - 4 : $urandom_range(0, 15) - 8;
      rs1 = ($urandom_range(0, 4) != 0) ? $urandom_range(0, 8) - 4 : $urandom_range(0, 15) - 8;
      imm = ($urandom_range(0, 4) != 0) ? $urandom_range(0, 8) - 4 : $urandom_range(0, 15) - 8;
      test_txn($sformatf("rnd%0d", n), mn, rd, rs1, imm, "", 3);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_imm_range();
    test_illegal();
    test_hold();
    test_reset_midconv();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btisa_encoder.md
Name: btisa_encoder

Overview:
- Sequential BTISA instruction encoder, the inverse of the instruction decoder.
- Accepts a mnemonic code and binary register/immediate fields. Converts each field to balanced ternary one trit per cycle, then emits a 9-trit instruction word plus an instruction-memory write address.
- Used by the program loader / debug port to write trit-encoded programs into instruction memory.

Parameters:
- ADDR_W, 8, width of the output write-address counter (wraps at 2**ADDR_W).
- FLD_W, 4, width of the signed two's-complement rd/rs1/imm inputs.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept a request
- in_mnem  in  5  mnemonic code (btisa_mnem_e)
- in_rd  in  FLD_W  signed destination register index
- in_rs1  in  FLD_W  signed source register index
- in_imm  in  FLD_W  signed rs2/immediate value
- addr_clr  in  1  synchronous clear of the address counter
- out_valid  out  1  encoded word valid
- out_ready  in  1  consumer accepts the word
- out_instr  out  9×trit_t  encoded instruction: [8:6] opcode, [5:4] rd, [3:2] rs1, [1:0] rs2/imm
- out_addr  out  ADDR_W  write address for out_instr
- out_err  out  1  request was illegal; out_instr is all T_ZERO

Behaviour:
- Reset is asynchronous and active-high, named rst, on the single clock clk. Reset values:
  - in_ready=1, out_valid=0, out_err=0, out_addr=0
  - out_instr all T_ZERO, FSM in IDLE
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - Accept on in_valid&&in_ready: latch all inputs.
  - Legality check in the same cycle:
    - mnemonic must be defined;
    - each field must lie in -4..+4.
  - Illegal request → DONE with out_err=1. out_valid rises the cycle after acceptance (1-cycle latency).
  - Legal request → CONV.
- CONV:
  - 6 cycles, in_ready=0.
  - Step counter 0..5 processes rd, rs1, imm in that order, LSB trit first.
  - Per step, working value v: r = v mod 3 (normalised to 0..2).
    - r=0 → trit T_ZERO, v=v/3
    - r=1 → trit T_POS_ONE, v=(v-1)/3
    - r=2 → trit T_NEG_ONE, v=(v+1)/3
  - Use exact division; no truncation error for legal inputs.
  - Opcode trits come from a combinational lookup of the latched mnemonic in the step-0 cycle.
  - After step 5 → DONE. out_valid rises 7 cycles after the acceptance edge.
- DONE:
  - out_valid=1, in_ready=0.
  - out_instr, out_addr and out_err are held stable until out_ready.
  - On out_valid&&out_ready → IDLE.
  - out_addr increments (mod 2**ADDR_W) only on a completed handshake with out_err=0.
- Single outstanding request; no overlap. in_ready returns high the cycle after the output handshake.
- addr_clr:
  - sets out_addr=0 next cycle in any state;
  - wins over a simultaneous increment;
  - if asserted while out_valid=1, the held word's address becomes 0 in the same cycle.
- Mnemonic map (encoding order is opcode trit 8, 7, 6):
  - 000=ADD, 00+=SUB, 00-=NEG, 0+0=MUL, 0++=SHL, 0+-=SHR
  - 0-0=BEQ, 0-0=ADDI (alias), 0-+=BNE, 0--=BLT
  - +00=MIN, +0+=MAX, +0-=XOR, ++0=INV, +++=PTI, ++-=NTI
  - +-0=JAL, +-+=JALR, +--=JR
  - -00=LD, -0+=ST, -0-=LDT, -+0=STT, -++=LUI
  - --0=NOP, --+=HALT, ---=ECALL
  - -+- is unassigned: no mnemonic encodes it. Codes 27..31 are illegal.
- in_* inputs are ignored outside IDLE. Changing them mid-conversion has no effect.
- Reset asserted mid-CONV or mid-DONE: immediate return to reset values. The pending word is discarded and not emitted.

Optional Feature:
- Macro BTISA_ENC_IMM_SAT_EN.
- Defined: in_imm outside -4..+4 is saturated to ±4 and encoded normally, with out_err=0. Range errors on rd/rs1 and illegal mnemonics still raise out_err.
- Undefined: any out-of-range in_imm raises out_err.

Decomposition:
- ternary_pkg (shared) gains:
  - btisa_mnem_e, a 5-bit enum with 27 entries including ADDI;
  - BTISA_FIELD_MIN = -4 and BTISA_FIELD_MAX = +4;
  - function btisa_opcode_trits(btisa_mnem_e) returning trit_t[2:0], reused by assembler-side testbenches.
- One sub-module: bt_digit_step. Combinational; signed v in → one trit_t plus next v out. Instantiated once and time-multiplexed over the 6 steps.

Test Plan:
- ADD, rd=1, rs1=-1, imm=4 → after 7 cycles out_instr = 000 0+ 0- ++; out_err=0; out_addr=0, then 1 after handshake.
- HALT, fields 0,0,0 → out_instr = --+ 00 00 00. Back-to-back with ADDI rd=-4, rs1=3, imm=-2 → 0-0 -- +0 -+; out_addr=1.
- imm=5 → macro off: out_err=1 one cycle after accept, out_instr all zero, out_addr unchanged. Macro on: imm field ++, out_err=0.
- in_mnem=27, or rd=-5 → out_err=1 with 1-cycle latency in both macro builds.
- out_ready held low 5 cycles in DONE → out_instr/out_addr stable, in_ready=0, no address increment. Assert addr_clr during the hold → out_addr=0 before the handshake.
- rst pulsed on the 3rd CONV cycle → out_valid=0, in_ready=1, out_addr=0 immediately. A following NOP request yields --0 00 00 00 with no remnant trits.
